// File: rtl/dbus_mem_responder.sv
// Data-bus responder: serves load/store requests from an internal doubleword RAM after a programmable latency.
// Define DBUS_RAND_LATENCY_EN to add 0..7 LFSR-driven extra wait cycles to every accepted request.
package dbus_pkg;
    typedef struct packed {
        logic        valid;
        logic [63:0] addr;
        logic [2:0]  size;
        logic [7:0]  strobe;
        logic [63:0] data;
    } dbus_req_t;

    typedef struct packed {
        logic        addr_ok;
        logic        data_ok;
        logic [63:0] data;
    } dbus_resp_t;
endpackage

module dbus_mem_responder
    import dbus_pkg::*;
#(
    parameter int unsigned DEPTH     = 4096,
    parameter logic [63:0] BASE      = 64'h8000_0000,
    parameter int unsigned LATENCY   = 1,
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input  logic       clk,
    input  logic       reset,
    input  dbus_req_t  dreq,
    output dbus_resp_t dresp,
    output logic       access_err
);
    localparam int unsigned IW   = $clog2(DEPTH);
    localparam logic [63:0] SPAN = 64'(DEPTH) << 3;
`ifdef DBUS_RAND_LATENCY_EN
    localparam int unsigned CW = 9;
`else
    localparam int unsigned CW = 8;
`endif

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t          state;
    state_t          next_state;
    logic [CW-1:0]   count;
    logic [CW-1:0]   load_val;
    logic [IW-1:0]   idx_q;
    logic            in_range_q;
    logic [7:0]      strobe_q;
    logic [63:0]     wdata_q;
    logic [2:0]      size_q;
    logic [63:0]     rdata;
    logic [63:0]     mem [DEPTH];

    logic [63:0]     cur_off;
    logic            cur_in_range;
    logic [IW-1:0]   cur_idx;
    logic            sel_in_range;
    logic [IW-1:0]   sel_idx;
    logic            size_unused;
    logic            resp_now;

    // addr[2:0] never takes part in indexing; misalignment is the initiator's concern
    assign cur_off      = dreq.addr - BASE;
    assign cur_in_range = (dreq.addr >= BASE) && (cur_off < SPAN);
    assign cur_idx      = cur_off[IW+2:3];

    // A zero-latency request goes straight from IDLE to RESP before its latches are visible
    assign sel_in_range = (state == IDLE) ? cur_in_range : in_range_q;
    assign sel_idx      = (state == IDLE) ? cur_idx : idx_q;

    // Size is latched for visibility only; the data path always moves whole doublewords
    assign size_unused  = ^size_q;

`ifdef DBUS_RAND_LATENCY_EN
    logic [15:0] lfsr;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lfsr <= LFSR_SEED;
        end else begin
            lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
        end
    end

    assign load_val = CW'(LATENCY) + CW'(lfsr[2:0]);
`else
    assign load_val = CW'(LATENCY);
`endif

    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (dreq.valid) begin
                    next_state = (load_val == '0) ? RESP : WAIT;
                end
            end
            WAIT: begin
                if (!dreq.valid) begin
                    next_state = IDLE;
                end else if (count <= CW'(1)) begin
                    next_state = RESP;
                end
            end
            RESP:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Read data is captured on the edge into RESP, so it always precedes this request's own write
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            count      <= '0;
            idx_q      <= '0;
            in_range_q <= 1'b0;
            strobe_q   <= '0;
            wdata_q    <= '0;
            size_q     <= '0;
            rdata      <= '0;
        end else begin
            state <= next_state;
            if (state == IDLE && dreq.valid) begin
                idx_q      <= cur_idx;
                in_range_q <= cur_in_range;
                strobe_q   <= dreq.strobe;
                wdata_q    <= dreq.data;
                size_q     <= dreq.size;
                count      <= load_val;
            end else if (state == WAIT) begin
                count <= count - CW'(1);
            end
            if (next_state == RESP) begin
                rdata <= sel_in_range ? mem[sel_idx] : '0;
            end
        end
    end

    // The write lands on the edge that closes RESP; a reset during RESP cancels it
    always_ff @(posedge clk) begin
        if (state == RESP && in_range_q && !reset) begin
            for (int i = 0; i < 8; i++) begin
                if (strobe_q[i]) begin
                    mem[idx_q][i*8 +: 8] <= wdata_q[i*8 +: 8];
                end
            end
        end
    end

    assign resp_now   = (state == RESP);
    assign dresp      = '{addr_ok: resp_now, data_ok: resp_now, data: rdata};
    assign access_err = resp_now && !in_range_q;

endmodule

// File: tb/tb_dbus_mem_responder.sv
// Randomised bench for dbus_mem_responder: a queue-based reference model predicts each response window and data.
// Honours DBUS_RAND_LATENCY_EN by widening the expected response window to LATENCY..LATENCY+7 extra cycles.
module tb_dbus_mem_responder;
    import dbus_pkg::*;

    localparam int unsigned DEPTH = 64;
    localparam logic [63:0] BASE  = 64'h8000_0000;
    localparam int          LAT   = 2;
`ifdef DBUS_RAND_LATENCY_EN
    localparam int SPREAD = 7;
    localparam int NRAND  = 1000;
`else
    localparam int SPREAD = 0;
    localparam int NRAND  = 300;
`endif

    typedef struct {
        int          lo;
        int          hi;
        logic [63:0] data;
        bit          chk;
        bit          err;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset;
    dbus_req_t  dreq;
    dbus_resp_t dresp;
    logic       access_err;

    int          cyc = 0;
    int          n_checks = 0;
    int          n_pass = 0;
    bit          at_resp = 0;
    bit          prev_ok = 0;
    exp_t        q[$];
    logic [63:0] mm [DEPTH];
    bit          known [DEPTH];

    dbus_mem_responder #(
        .DEPTH(DEPTH), .BASE(BASE), .LATENCY(LAT), .LFSR_SEED(16'hACE1)
    ) dut (
        .clk(clk), .reset(reset), .dreq(dreq), .dresp(dresp), .access_err(access_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: time %0t reached, required completion earlier", $time);
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic check(input bit ok, input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (ok) n_pass++;
        else $display("[TB] FAIL %s: actual %h required %h", name, act, req);
    endtask

    task automatic check_lat(input int lat, input string name);
        check(lat >= LAT + 1 && lat <= LAT + 1 + SPREAD, name, lat, LAT + 1);
    endtask

    // Compare process: every cycle, outputs must match the front of the expected-response queue
    always @(negedge clk) begin
        if (reset) begin
            check(!dresp.data_ok && !dresp.addr_ok && !access_err && dresp.data == 64'h0,
                  "reset_outputs", {dresp.addr_ok, dresp.data_ok, access_err}, 0);
            q.delete();
            prev_ok = 0;
        end else begin
            if (q.size() > 0 && cyc >= q[0].lo) begin
                if (dresp.data_ok) begin
                    check(cyc <= q[0].hi, "resp_cycle", cyc, q[0].hi);
                    check(dresp.addr_ok, "addr_ok", dresp.addr_ok, 1);
                    if (q[0].chk) check(dresp.data == q[0].data, "resp_data", dresp.data, q[0].data);
                    check(access_err == q[0].err, "access_err", access_err, q[0].err);
                    void'(q.pop_front());
                end else if (cyc >= q[0].hi) begin
                    check(0, "resp_missing", 0, 1);
                    void'(q.pop_front());
                end else begin
                    check(!dresp.addr_ok && !access_err, "wait_outputs", {dresp.addr_ok, access_err}, 0);
                end
            end else begin
                check(!dresp.data_ok && !dresp.addr_ok && !access_err, "no_resp",
                      {dresp.addr_ok, dresp.data_ok, access_err}, 0);
            end
            check(!(prev_ok && dresp.data_ok), "consecutive_data_ok", {prev_ok, dresp.data_ok}, 0);
            prev_ok = dresp.data_ok;
        end
    end

    task automatic idle(input int n);
        dreq.valid = 1'b0;
        repeat (n) @(negedge clk);
        at_resp = 0;
    endtask

    // Issues one request; abort_after > 0 drops valid that many cycles after acceptance
    task automatic applyStimulus(input logic [63:0] a, input logic [7:0] s, input logic [63:0] d,
                                 input int abort_after, input bit reset_in_resp,
                                 output logic [63:0] got, output bit got_err, output int lat);
        logic [63:0] off;
        bit          inr;
        int          idx;
        int          t;
        bit          seen;
        exp_t        e;
        off = a - BASE;
        inr = (a >= BASE) && (off < 64'(DEPTH) * 64'd8);
        idx = inr ? int'(off >> 3) : 0;
        t   = at_resp ? cyc + 1 : cyc;
        dreq.valid  = 1'b1;
        dreq.addr   = a;
        dreq.size   = 3'd3;
        dreq.strobe = s;
        dreq.data   = d;
        got = '0;
        got_err = 0;
        lat = -1;
        if (abort_after > 0) begin
            while (cyc < t + abort_after) @(negedge clk);
            dreq.valid = 1'b0;
            @(negedge clk);
            at_resp = 0;
            return;
        end
        e.lo   = t + 1 + LAT;
        e.hi   = e.lo + SPREAD;
        e.data = inr ? mm[idx] : 64'h0;
        e.chk  = !inr || known[idx];
        e.err  = !inr;
        q.push_back(e);
        if (inr && s != 8'h00 && !reset_in_resp) begin
            for (int i = 0; i < 8; i++) if (s[i]) mm[idx][i*8 +: 8] = d[i*8 +: 8];
            if (s == 8'hFF) known[idx] = 1;
        end
        seen = 0;
        for (int k = 0; k < LAT + SPREAD + 4 && !seen; k++) begin
            @(negedge clk);
            if (dresp.data_ok) seen = 1;
        end
        check(seen, "resp_timeout", seen, 1);
        got     = dresp.data;
        got_err = access_err;
        lat     = cyc - t;
        at_resp = seen;
        if (!seen) dreq.valid = 1'b0;
        if (seen && reset_in_resp) begin
            #2 reset = 1'b1;
            dreq.valid = 1'b0;
            #1;
            check(!dresp.data_ok && !dresp.addr_ok && !access_err && dresp.data == 64'h0,
                  "reset_in_resp_outputs", {dresp.addr_ok, dresp.data_ok, access_err}, 0);
            @(negedge clk);
            reset = 1'b0;
            at_resp = 0;
        end
    endtask

    task automatic reset_in_wait(input logic [63:0] a, input logic [63:0] d);
        dreq.valid  = 1'b1;
        dreq.addr   = a;
        dreq.strobe = 8'hFF;
        dreq.data   = d;
        @(negedge clk);
        #2 reset = 1'b1;
        dreq.valid = 1'b0;
        #1;
        check(!dresp.data_ok && !dresp.addr_ok && !access_err && dresp.data == 64'h0,
              "reset_in_wait_outputs", {dresp.addr_ok, dresp.data_ok, access_err}, 0);
        @(negedge clk);
        reset = 1'b0;
        at_resp = 0;
    endtask

    task automatic checkOutput(input logic [63:0] got, input logic [63:0] req, input string name);
        check(got === req, name, got, req);
    endtask

    initial begin
        logic [63:0] got;
        bit          err;
        int          lat;
        int          c1;
        int          c2;
        logic [63:0] a;
        logic [7:0]  s;
        int          r;
        int          ab;

        reset = 1'b1;
        dreq  = '0;
        for (int i = 0; i < DEPTH; i++) begin
            known[i] = 0;
            mm[i] = '0;
        end
        repeat (3) @(negedge clk);
        check(!dresp.data_ok && !dresp.addr_ok && !access_err && dresp.data == 64'h0,
              "reset_values", dresp.data, 0);
        reset = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 16; i++)
            applyStimulus(BASE + 64'(i) * 8, 8'hFF, {$urandom, $urandom}, 0, 0, got, err, lat);
        idle(1);

        $display("[TB] directed: preload and read at BASE");
        applyStimulus(BASE, 8'hFF, 64'h1122334455667788, 0, 0, got, err, lat);
        idle(2);
        applyStimulus(BASE, 8'h00, 64'h0, 0, 0, got, err, lat);
        checkOutput(got, 64'h1122334455667788, "read_base");
        checkOutput(64'(err), 64'h0, "read_base_err");
        check_lat(lat, "read_base_latency");
        idle(1);

        $display("[TB] directed: partial strobe write");
        applyStimulus(BASE + 8, 8'hFF, 64'h0, 0, 0, got, err, lat);
        applyStimulus(BASE + 8, 8'h0F, 64'hFFFF_FFFF_FFFF_FFFF, 0, 0, got, err, lat);
        idle(1);
        applyStimulus(BASE + 8, 8'h00, 64'h0, 0, 0, got, err, lat);
        checkOutput(got, 64'h0000_0000_FFFF_FFFF, "strobe_merge");
        applyStimulus(BASE + 8 + 5, 8'h00, 64'h0, 0, 0, got, err, lat);
        checkOutput(got, 64'h0000_0000_FFFF_FFFF, "misaligned_read");
        idle(1);

        $display("[TB] directed: back-to-back write then read");
        applyStimulus(BASE, 8'hFF, 64'hA5, 0, 0, got, err, lat);
        c1 = cyc;
        applyStimulus(BASE, 8'h00, 64'h0, 0, 0, got, err, lat);
        c2 = cyc;
        checkOutput(got, 64'hA5, "b2b_read");
        check(c2 - c1 >= LAT + 2 && c2 - c1 <= LAT + 2 + SPREAD, "b2b_gap", c2 - c1, LAT + 2);
        idle(1);

        $display("[TB] directed: out-of-range accesses");
        applyStimulus(BASE + 64'(DEPTH) * 8, 8'h00, 64'h0, 0, 0, got, err, lat);
        checkOutput(got, 64'h0, "oor_read_data");
        checkOutput(64'(err), 64'h1, "oor_read_err");
        applyStimulus(BASE + 64'(DEPTH) * 8, 8'hFF, 64'hFFFF_FFFF_FFFF_FFFF, 0, 0, got, err, lat);
        applyStimulus(BASE - 8, 8'h00, 64'h0, 0, 0, got, err, lat);
        checkOutput(64'(err), 64'h1, "below_base_err");
        applyStimulus(BASE, 8'h00, 64'h0, 0, 0, got, err, lat);
        checkOutput(got, 64'hA5, "oor_write_dropped");
        idle(1);

        $display("[TB] directed: aborts and resets");
        applyStimulus(BASE + 16, 8'hFF, 64'h5555_5555_5555_5555, 0, 0, got, err, lat);
        idle(1);
        applyStimulus(BASE + 16, 8'hFF, 64'hDEAD_BEEF_0BAD_F00D, 1, 0, got, err, lat);
        applyStimulus(BASE + 16, 8'h0F, 64'h1234_5678_9ABC_DEF0, LAT, 0, got, err, lat);
        applyStimulus(BASE + 16, 8'h00, 64'h0, 0, 0, got, err, lat);
        checkOutput(got, 64'h5555_5555_5555_5555, "abort_no_write");
        idle(1);
        reset_in_wait(BASE + 16, 64'h1111_2222_3333_4444);
        applyStimulus(BASE + 16, 8'h00, 64'h0, 0, 0, got, err, lat);
        checkOutput(got, 64'h5555_5555_5555_5555, "reset_wait_discard");
        check_lat(lat, "post_reset_latency");
        idle(1);
        applyStimulus(BASE + 16, 8'hFF, 64'h9999_9999_9999_9999, 0, 1, got, err, lat);
        applyStimulus(BASE + 16, 8'h00, 64'h0, 0, 0, got, err, lat);
        checkOutput(got, 64'h5555_5555_5555_5555, "reset_resp_discard");
        idle(1);

        $display("[TB] random traffic: %0d requests", NRAND);
        for (int i = 0; i < NRAND; i++) begin
            r = int'($urandom_range(0, 99));
            if (r < 4) a = BASE + 64'(DEPTH) * 8 + 64'($urandom_range(0, 255));
            else if (r < 8) a = BASE - 64'($urandom_range(1, 256));
            else a = BASE + 64'($urandom_range(0, 15)) * 8 + 64'($urandom_range(0, 7));
            s  = ($urandom_range(0, 99) < 40) ? 8'($urandom) : 8'h00;
            ab = ($urandom_range(0, 99) < 5) ? int'($urandom_range(1, LAT)) : 0;
            applyStimulus(a, s, {$urandom, $urandom}, ab, 0, got, err, lat);
            if (ab == 0) check_lat(lat, "rand_latency");
            if ($urandom_range(0, 1) == 1) idle(int'($urandom_range(1, 3)));
        end
        idle(LAT + SPREAD + 4);
        check(q.size() == 0, "queue_drained", q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
